// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding and word constants.
package dmem_pkg;

   typedef enum logic [1:0] {
      DM_IDLE,
      DM_RD_WAIT,
      DM_RMW_WR
   } dmemState_e;

   localparam int unsigned WORD_BYTES = 4;
   localparam int unsigned OFF_W      = $clog2(WORD_BYTES);
   localparam logic [31:0] FULL_MASK  = 32'hFFFFFFFF;

endpackage

// File: rtl/dmem_rd_align.sv
// Right-justifies a load word by its byte offset; vacated upper bytes are zero-filled.
module dmem_rd_align
   import dmem_pkg::*;
(
   input  logic [31:0]      word,
   input  logic [OFF_W-1:0] off,
   output logic [31:0]      data
);

   always_comb begin
      data = word >> {off, 3'b000};
   end

endmodule

// File: rtl/dmem_responder.sv
// LSU-to-SRAM responder: single-cycle full stores, RMW partial stores, 2-cycle aligned loads.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned ADDR_W         = 14,
   parameter bit          FULL_MASK_FAST = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_rd_en,
   input  logic              req_wr_en,
   input  logic [31:0]       req_bit_wr_en,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wr_data,
   output logic              stall,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rd_data,
   output logic              sram_cs,
   output logic              sram_we,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [31:0]       sram_wdata,
   input  logic [31:0]       sram_rdata
);

   dmemState_e        state;
   logic [ADDR_W-1:0] lat_idx;
   logic [OFF_W-1:0]  lat_off;
   logic [31:0]       lat_mask;
   logic [31:0]       lat_data;

   logic [ADDR_W-1:0] req_idx;
   logic [OFF_W-1:0]  req_off;
   logic [31:0]       aligned;
   logic              wr_active;
   logic              wr_fast;
   logic              addr_unused;

   assign req_idx     = req_addr[ADDR_W+1:2];
   assign req_off     = req_addr[OFF_W-1:0];
   assign addr_unused = ^req_addr[31:ADDR_W+2];
   assign wr_active   = req_wr_en && (req_bit_wr_en != '0);
   assign wr_fast     = FULL_MASK_FAST && (req_bit_wr_en == FULL_MASK);

   dmem_rd_align u_align (
      .word (sram_rdata),
      .off  (lat_off),
      .data (aligned)
   );

   // SRAM controls are combinational so the macro sees the request in its acceptance cycle;
   // reset gates everything, which also drops an in-flight RMW write.
   always_comb begin
      stall       = 1'b0;
      rsp_valid   = 1'b0;
      rsp_rd_data = '0;
      sram_cs     = 1'b0;
      sram_we     = 1'b0;
      sram_addr   = '0;
      sram_wdata  = '0;
      if (!rst) begin
         unique case (state)
            DM_IDLE: begin
               if (wr_active) begin
                  sram_cs   = 1'b1;
                  sram_addr = req_idx;
                  if (wr_fast) begin
                     sram_we    = 1'b1;
                     sram_wdata = req_wr_data;
                  end else begin
                     stall = 1'b1;
                  end
               end else if (req_rd_en && !req_wr_en) begin
                  sram_cs   = 1'b1;
                  sram_addr = req_idx;
                  stall     = 1'b1;
               end
            end
            DM_RD_WAIT: begin
               rsp_valid   = 1'b1;
               rsp_rd_data = aligned;
            end
            DM_RMW_WR: begin
               sram_cs    = 1'b1;
               sram_we    = 1'b1;
               sram_addr  = lat_idx;
               sram_wdata = (sram_rdata & ~lat_mask) | (lat_data & lat_mask);
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= DM_IDLE;
         lat_idx  <= '0;
         lat_off  <= '0;
         lat_mask <= '0;
         lat_data <= '0;
      end else begin
         unique case (state)
            DM_IDLE: begin
               if (wr_active || (req_rd_en && !req_wr_en)) begin
                  lat_idx  <= req_idx;
                  lat_off  <= req_off;
                  lat_mask <= req_bit_wr_en;
                  lat_data <= req_wr_data;
               end
               if (wr_active) begin
                  if (!wr_fast) state <= DM_RMW_WR;
               end else if (req_rd_en && !req_wr_en) begin
                  state <= DM_RD_WAIT;
               end
            end
            DM_RD_WAIT: state <= DM_IDLE;
            DM_RMW_WR:  state <= DM_IDLE;
            default:    state <= DM_IDLE;
         endcase
      end
   end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the core's load/store unit. It accepts word-addressed requests carrying a 32-bit bit-write mask, and services them against a single-port, word-wide SRAM macro that has no bit/byte enables.
- Partial writes are done as read-modify-write. Reads return data right-justified by byte offset, so the load unit can sign- or zero-extend from bit 0.
- Sits between the core's LSU outputs and the data SRAM. Drives a stall back to the pipeline.

Parameters:
- ADDR_W, 14, SRAM word-index width; word index = req_addr[ADDR_W+1:2], higher address bits ignored.
- FULL_MASK_FAST, 1, when 1 a write with mask 32'hFFFFFFFF skips the RMW read and completes in one cycle.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous active-high reset.
- req_rd_en  in  1  load request.
- req_wr_en  in  1  store request.
- req_bit_wr_en  in  32  per-bit write mask, already lane-positioned.
- req_addr  in  32  byte address.
- req_wr_data  in  32  lane-positioned store data.
- stall  out  1  pipeline must hold the request stable this cycle.
- rsp_valid  out  1  load data valid this cycle.
- rsp_rd_data  out  32  SRAM word shifted right by 8*req_addr[1:0].
- sram_cs  out  1  SRAM chip select.
- sram_we  out  1  SRAM write (1) / read (0).
- sram_addr  out  ADDR_W  SRAM word index.
- sram_wdata  out  32  SRAM write word.
- sram_rdata  in  32  SRAM read word, valid the cycle after a read is selected.

Behaviour:
- Interface fixed: one clock, clk; reset rst, synchronous, active-high.
- States: DM_IDLE, DM_RD_WAIT, DM_RMW_WR.
- Latched on acceptance, in DM_IDLE only: word index, addr[1:0], mask, wr_data.
- Reset values: state=DM_IDLE; latched registers=0; stall=0, rsp_valid=0, rsp_rd_data=0, sram_cs=0, sram_we=0, sram_addr=0, sram_wdata=0.
- While rst=1: sram_cs and sram_we are forced to 0, including any RMW write in flight. An in-flight RMW is dropped and no partial write reaches the SRAM.
- Request priority: req_wr_en wins over req_rd_en if both are high; the read is ignored.
- DM_IDLE, no request: sram_cs=0, stall=0.
- Load:
  - Cycle 0, DM_IDLE: sram_cs=1, sram_we=0, stall=1; go to DM_RD_WAIT.
  - Cycle 1, DM_RD_WAIT: rsp_valid=1, rsp_rd_data = sram_rdata >> (8*off), zero-filled; stall=0; go to DM_IDLE.
  - Load-to-use latency is 2 cycles.
- Store with mask == 0: no SRAM access, stall=0, stays in DM_IDLE.
- Store with mask all-ones and FULL_MASK_FAST=1: cycle 0, sram_cs=1, sram_we=1, sram_wdata=req_wr_data, stall=0; stays in DM_IDLE.
- Other stores (partial mask, or FULL_MASK_FAST=0):
  - Cycle 0, DM_IDLE: read the word, stall=1; go to DM_RMW_WR.
  - Cycle 1, DM_RMW_WR: sram_cs=1, sram_we=1, sram_wdata = (sram_rdata & ~mask) | (wr_data & mask); stall=0; go to DM_IDLE.
- Outside DM_IDLE, request inputs are ignored; latched values are used.
- stall is combinational from state and request inputs. It is never asserted in DM_RD_WAIT or DM_RMW_WR.
- Back-to-back operations: a new request presented the cycle after completion is accepted in DM_IDLE with no bubble.
- rsp_rd_data is 0 whenever rsp_valid=0.
- Misaligned halfword/word offsets are not split. Bytes shifted past bit 31 are lost, and upper bits are 0.

Decomposition:
- Shared core package gets:
  - dmemState_e {DM_IDLE, DM_RD_WAIT, DM_RMW_WR};
  - constant WORD_BYTES=4;
  - constant FULL_MASK=32'hFFFFFFFF.
- One sub-module, dmem_rd_align: combinational byte right-shift by offset, 2-bit offset to 32-bit output.
- FSM, latches and merge stay in dmem_responder.

Test Plan:
- Full store: preload word 0x10 = 0; req_wr_en=1, addr=0x40, mask=FFFFFFFF, data=DEADBEEF -> one-cycle write, stall=0; then load addr 0x40 -> rsp_rd_data=DEADBEEF in cycle 1, stall=1 in cycle 0 only.
- Byte RMW: word 0x10 = 11223344; store addr=0x42, mask=00FF0000, data=00AA0000 -> stall=1 one cycle, SRAM written 11AA3344; load addr 0x42 -> rsp_rd_data=000011AA.
- Halfword RMW: word = 11223344; store addr=0x42, mask=FFFF0000, data=BEEF0000 -> BEEF3344; load addr 0x43 -> rsp_rd_data=000000BE.
- Zero mask and priority: req_wr_en=1, mask=0 -> sram_cs=0, stall=0; then req_wr_en=req_rd_en=1 with full mask -> write only, rsp_valid never 1.
- Reset mid-RMW: start partial store, assert rst in the DM_RMW_WR cycle -> sram_we=0, word unchanged, state DM_IDLE, all outputs 0 next cycle.
- Back-to-back: load, partial store, load to the same word with no idle cycles -> second load returns the merged value; total 6 cycles.
